cpu_sequencer: RTL
==================

# cpu_sequencer

Multicycle instruction sequencer for the five-stage (IF, DE, RF, EX, WB) processor core. It steps the core through one stage per cycle and emits one-hot stage enables. It owns the shared memory port handshake for instruction fetch and load/store writeback. It also handles halt instructions, external stop requests and memory timeouts, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter
- WAIT_MAX, 15, maximum no-ack wait cycles before a memory timeout
- TO_W, 4, width of the wait counter; must hold WAIT_MAX

Ports:
- m_clock  in  1  clock, rising edge
- p_reset  in  1  reset; one clock, asynchronous assert, active-low (0 = reset)
- start  in  1  level; begins execution from IDLE or HALT
- stop  in  1  request to halt at the next instruction boundary
- mem_ack  in  1  memory completion, valid in the cycle mem_req is high
- is_mem  in  1  decoded instruction accesses memory; sampled in DE
- is_store  in  1  decoded access is a write; sampled in DE
- is_halt  in  1  decoded instruction is HALT; sampled in DE
- en_if, en_de, en_rf, en_ex, en_wb  out  1 each  one-hot stage enables
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable; qualifies mem_req
- busy  out  1  state in IF..WB
- halted  out  1  state == HALT
- timeout_err  out  1  state == ERR
- retired  out  CNT_W  retired-instruction count
- state  out  3  current state, for debug

## Operation
- State encoding: IDLE=0, IF=1, DE=2, RF=3, EX=4, WB=5, HALT=6, ERR=7.
- Reset forces state=IDLE, retired=0, wait_cnt=0, stop_pending=0 and all latched decode flags=0. All outputs are therefore 0.
- Output decode (from registered state and flags only):
  - en_* is 1 only in the matching state.
  - mem_req = (state==IF) | (state==WB & mem_f).
  - mem_we = (state==WB & mem_f & st_f).
- IDLE: start=1 moves to IF. stop is ignored.
- IF: holds until mem_ack=1, then moves to DE.
- DE: latches mem_f<=is_mem, st_f<=is_store.
  - If is_halt=1: moves to HALT and increments retired.
  - Otherwise moves to RF.
- RF moves to EX. EX moves to WB. Both take exactly one cycle.
- WB:
  - If mem_f=0, completes in one cycle.
  - If mem_f=1, holds until mem_ack=1.
  - On completion, retired increments. The next state is HALT if stop_pending=1 (or stop=1 this cycle), otherwise IF.
- HALT: start=1 moves to IF. stop_pending is cleared on entry to HALT.
- ERR: sticky. Only p_reset exits it. start and stop are ignored.
- stop: sampled in any busy state. It sets stop_pending, which is honoured only at WB completion. An in-flight instruction is never aborted.
- start while busy, halted-by-stop mid-flight, or in ERR has no effect beyond the rules above.
- Memory wait:
  - wait_cnt clears on every state change.
  - In a waiting state (IF, or WB with mem_f=1), each cycle with mem_ack=0: if wait_cnt==WAIT_MAX, go to ERR; otherwise wait_cnt++.
  - mem_ack=1 has priority over timeout in the same cycle.
  - An access is therefore accepted within WAIT_MAX+1 cycles of mem_req rising.
- retired wraps modulo 2^CNT_W without a flag.
- Illegal state values (none are reachable) go to IDLE.

## Timing
- start is sampled at a rising edge; en_if=1 from the next cycle.
- Non-memory instruction with mem_ack in its first IF cycle: 5 cycles IF..WB. retired updates at the edge ending WB.
- Each no-ack cycle adds one cycle to IF or WB.
- mem_req stays high continuously through a wait. It drops the cycle after the ack edge.
- A stop asserted during the WB completion cycle itself is honoured (same-cycle priority).
- Asynchronous reset mid-instruction drops mem_req immediately, with no clock needed.

## Test plan
- Reset, then start pulse, always-ack memory, 3 non-mem instructions, then is_halt in DE of the 4th → exact IF,DE,RF,EX,WB ×3 sequence, HALT at cycle 19, retired=4, halted=1.
- Load with 2 no-ack cycles in IF and 3 in WB (is_mem=1, is_store=0) → mem_req high 3 then 4 cycles, mem_we=0, instruction takes 10 cycles, retired=1.
- Store (is_store=1) → mem_we=1 only in WB while mem_req=1.
- No ack in IF for WAIT_MAX+1=16 cycles → ERR on the next edge with timeout_err=1. Ack arriving on the 16th cycle instead gives DE, not ERR. start in ERR has no effect.
- stop pulsed in RF → current instruction finishes WB and retires, then HALT. A following start resumes in IF with stop_pending=0.
- retired preset by running 2^CNT_W instructions (CNT_W=4 build: 16) → wraps to 0. p_reset low during EX → all outputs 0 immediately, state=IDLE.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle IF/DE/RF/EX/WB sequencer for the five-stage core.
// It owns the shared memory handshake, enforces a bounded memory wait,
// honours halt instructions and stop requests at instruction boundaries,
// and counts retired instructions. All outputs are flops loaded from the
// next-state decode, so they track the state register cycle for cycle and
// clear asynchronously with p_reset.

module cpu_sequencer #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15,
  parameter int TO_W     = 4
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mem_ack,
  input  logic             is_mem,
  input  logic             is_store,
  input  logic             is_halt,
  output logic             en_if,
  output logic             en_de,
  output logic             en_rf,
  output logic             en_ex,
  output logic             en_wb,
  output logic             mem_req,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_DE   = 3'd2,
    S_RF   = 3'd3,
    S_EX   = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [TO_W-1:0]  wait_r;
  logic [TO_W-1:0]  wait_nxt_s;
  logic             stop_pend_r;
  logic             stop_pend_nxt_s;
  logic             mem_f_r;
  logic             mem_f_nxt_s;
  logic             st_f_r;
  logic             st_f_nxt_s;
  logic             retire_s;
  logic             wait_expired_s;
  logic [CNT_W-1:0] retired_r;

  // True for the five pipeline stages that make up an instruction in flight.
  function automatic logic is_busy_state(input state_t s);
    logic b;
    case (s)
      S_IF, S_DE, S_RF, S_EX, S_WB: b = 1'b1;
      default:                      b = 1'b0;
    endcase
    return b;
  endfunction

  assign wait_expired_s = (wait_r == TO_W'(WAIT_MAX));

  // Next-state, wait-counter, stop-pending and decode-flag logic.
  always_comb begin
    next_s          = state_r;
    wait_nxt_s      = wait_r;
    stop_pend_nxt_s = stop_pend_r;
    mem_f_nxt_s     = mem_f_r;
    st_f_nxt_s      = st_f_r;
    retire_s        = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_s = S_IF;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_IF: begin
        // Ack wins over an expiring wait in the same cycle.
        if (mem_ack) begin
          next_s = S_DE;
        end else if (wait_expired_s) begin
          next_s = S_ERR;
        end else begin
          wait_nxt_s = wait_r + TO_W'(1);
        end
      end
      S_DE: begin
        mem_f_nxt_s = is_mem;
        st_f_nxt_s  = is_store;
        if (is_halt) begin
          next_s   = S_HALT;
          retire_s = 1'b1;
        end else begin
          next_s = S_RF;
        end
      end
      S_RF: begin
        next_s = S_EX;
      end
      S_EX: begin
        next_s = S_WB;
      end
      S_WB: begin
        if (!mem_f_r || mem_ack) begin
          retire_s = 1'b1;
          // A stop arriving in the completion cycle itself still counts.
          if (stop_pend_r || stop) begin
            next_s = S_HALT;
          end else begin
            next_s = S_IF;
          end
        end else if (wait_expired_s) begin
          next_s = S_ERR;
        end else begin
          wait_nxt_s = wait_r + TO_W'(1);
        end
      end
      S_HALT: begin
        if (start) begin
          next_s = S_IF;
        end else begin
          next_s = S_HALT;
        end
      end
      S_ERR: begin
        next_s = S_ERR;
      end
      default: begin
        next_s = S_IDLE;
      end
    endcase

    // Stop is remembered while busy and only acted on at WB completion.
    if (is_busy_state(state_r) && stop) begin
      stop_pend_nxt_s = 1'b1;
    end else begin
      stop_pend_nxt_s = stop_pend_nxt_s;
    end

    // Entering HALT consumes any pending stop.
    if (next_s == S_HALT) begin
      stop_pend_nxt_s = 1'b0;
    end else begin
      stop_pend_nxt_s = stop_pend_nxt_s;
    end

    // Each stage starts its memory wait budget from zero.
    if (next_s != state_r) begin
      wait_nxt_s = {TO_W{1'b0}};
    end else begin
      wait_nxt_s = wait_nxt_s;
    end
  end

  // State register, wait counter, pending stop and latched decode flags.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_r     <= S_IDLE;
      wait_r      <= {TO_W{1'b0}};
      stop_pend_r <= 1'b0;
      mem_f_r     <= 1'b0;
      st_f_r      <= 1'b0;
    end else begin
      state_r     <= next_s;
      wait_r      <= wait_nxt_s;
      stop_pend_r <= stop_pend_nxt_s;
      mem_f_r     <= mem_f_nxt_s;
      st_f_r      <= st_f_nxt_s;
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      retired_r <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  // Registered output decode, loaded from the state being entered.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      en_if       <= 1'b0;
      en_de       <= 1'b0;
      en_rf       <= 1'b0;
      en_ex       <= 1'b0;
      en_wb       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      en_if       <= (next_s == S_IF);
      en_de       <= (next_s == S_DE);
      en_rf       <= (next_s == S_RF);
      en_ex       <= (next_s == S_EX);
      en_wb       <= (next_s == S_WB);
      mem_req     <= (next_s == S_IF) || ((next_s == S_WB) && mem_f_nxt_s);
      mem_we      <= (next_s == S_WB) && mem_f_nxt_s && st_f_nxt_s;
      busy        <= is_busy_state(next_s);
      halted      <= (next_s == S_HALT);
      timeout_err <= (next_s == S_ERR);
    end
  end

  assign retired = retired_r;
  assign state   = state_r;

  cpu_sequencer_chk u_chk (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .en          ({en_wb, en_ex, en_rf, en_de, en_if}),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .busy        (busy),
    .halted      (halted),
    .timeout_err (timeout_err)
  );

endmodule

// Structural invariants of the sequencer outputs.
module cpu_sequencer_chk (
  input logic       m_clock,
  input logic       p_reset,
  input logic [4:0] en,
  input logic       mem_req,
  input logic       mem_we,
  input logic       busy,
  input logic       halted,
  input logic       timeout_err
);

  a_en_onehot: assert property (@(posedge m_clock) disable iff (!p_reset) $onehot0(en));
  a_we_req:    assert property (@(posedge m_clock) disable iff (!p_reset) mem_we |-> mem_req);
  a_busy_en:   assert property (@(posedge m_clock) disable iff (!p_reset) busy == (en != 5'd0));
  a_modes:     assert property (@(posedge m_clock) disable iff (!p_reset)
                                $onehot0({busy, halted, timeout_err}));

endmodule
